// File: rtl/glb_core_pc_rd_server_pkg.sv
// Shared global-buffer parameters and packet types for the parallel-config
// read chain.
//   - Address/data widths of the global buffer and the default bank geometry
//     and bank read latency used by the per-tile read server.
//   - rdrq_packet_t : read request  {rd_en, rd_addr}
//   - rdrs_packet_t : read response {rd_data_valid, rd_data}
package glb_core_pc_rd_server_pkg;

    localparam int NUM_GLB_TILES         = 16;
    localparam int TILE_SEL_ADDR_WIDTH   = $clog2(NUM_GLB_TILES);
    localparam int DFLT_BANKS_PER_TILE   = 2;
    localparam int DFLT_BANK_RD_LATENCY  = 1;
    localparam int BANK_SEL_ADDR_WIDTH   = $clog2(DFLT_BANKS_PER_TILE);
    localparam int BANK_ADDR_WIDTH       = 16;
    localparam int BANK_DATA_WIDTH       = 64;
    localparam int GLB_ADDR_WIDTH        = TILE_SEL_ADDR_WIDTH + BANK_SEL_ADDR_WIDTH
                                           + BANK_ADDR_WIDTH;

    typedef struct packed {
        logic                      rd_en;
        logic [GLB_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic                       rd_data_valid;
        logic [BANK_DATA_WIDTH-1:0] rd_data;
    } rdrs_packet_t;

endpackage

// File: rtl/glb_core_pc_rd_server_shift.sv
// glb_shift: generic clock-enabled shift register with synchronous reset.
// Ports:
//   clk, reset (sync, active-high), clk_en (advance when 1)
//   data_in  : value entering stage 0
//   data_out : value leaving the last stage
//   stages   : every stage, stage 0 = newest
module glb_shift #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clk_en,
    input  logic [DATA_WIDTH-1:0]               data_in,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]    stages
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else if (clk_en) begin
            stages[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign data_out = stages[DEPTH-1];

endmodule

// File: rtl/glb_core_pc_rd_server.sv
// glb_core_pc_rd_server: per-tile responder on the parallel-config read chain.
// Requests arrive from the west and are served locally, forwarded east or
// dropped; responses flow west, merging local bank data with relayed data.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   glb_tile_id                : this tile's index
//   cfg_tile_connected_east    : east neighbour present (forwarding allowed)
//   rdrq_packet_wsti / _esto   : request in from west / out to east
//   rdrs_packet_esti / _wsto   : response in from east / out to west
//   bank_rd_en/addr/data       : local bank read port
//   rd_pending                 : local reads in flight
//   rdrs_collision             : sticky, local and relayed response met
//   rdrq_drop_pulse            : one-cycle pulse per dropped request
//
// Both chains are valid-only: a packet is transferred in every cycle its
// valid bit (rd_en / rd_data_valid) is 1. There is no ready and no
// backpressure; every stage must accept one packet per cycle.
module glb_core_pc_rd_server
    import glb_core_pc_rd_server_pkg::*;
#(
    parameter int BANK_RD_LATENCY = DFLT_BANK_RD_LATENCY,
    parameter int BANKS_PER_TILE  = DFLT_BANKS_PER_TILE
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0]                  glb_tile_id,
    input  logic                                            cfg_tile_connected_east,
    input  rdrq_packet_t                                    rdrq_packet_wsti,
    output rdrq_packet_t                                    rdrq_packet_esto,
    input  rdrs_packet_t                                    rdrs_packet_esti,
    output rdrs_packet_t                                    rdrs_packet_wsto,
    output logic [BANKS_PER_TILE-1:0]                       bank_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0]                      bank_rd_addr,
    input  logic [BANKS_PER_TILE-1:0][BANK_DATA_WIDTH-1:0]  bank_rd_data,
    output logic                                            rd_pending,
    output logic                                            rdrs_collision,
    output logic                                            rdrq_drop_pulse
);

    // Bank field sits directly above the byte address; BANKS_PER_TILE must
    // be >= 2 and fit the bank field reserved in GLB_ADDR_WIDTH.
    localparam int BSEL_W  = $clog2(BANKS_PER_TILE);
    localparam int TRK_W   = 1 + BSEL_W;
    localparam int TRK_D   = BANK_RD_LATENCY + 1;

    logic [TILE_SEL_ADDR_WIDTH-1:0] rq_tile;
    logic [BSEL_W-1:0]              rq_bank;
    logic [BANK_ADDR_WIDTH-1:0]     rq_byte;
    logic                           is_local;
    logic                           is_fwd;
    logic                           is_drop;
    logic [BANKS_PER_TILE-1:0]      bank_onehot;

    logic [TRK_W-1:0]               trk_in;
    logic [TRK_W-1:0]               trk_tail;
    logic [TRK_D-1:0][TRK_W-1:0]    trk_stages;
    logic                           tail_valid;
    logic [BSEL_W-1:0]              tail_bank;

    assign rq_tile = rdrq_packet_wsti.rd_addr[GLB_ADDR_WIDTH-1 -: TILE_SEL_ADDR_WIDTH];
    assign rq_bank = rdrq_packet_wsti.rd_addr[BANK_ADDR_WIDTH +: BSEL_W];
    assign rq_byte = rdrq_packet_wsti.rd_addr[BANK_ADDR_WIDTH-1:0];

    always_comb begin
        is_local    = 1'b0;
        is_fwd      = 1'b0;
        is_drop     = 1'b0;
        bank_onehot = '0;
        if (rdrq_packet_wsti.rd_en) begin
            if (rq_tile == glb_tile_id) begin
                is_local             = 1'b1;
                bank_onehot[rq_bank] = 1'b1;
            end else if (cfg_tile_connected_east) begin
                is_fwd = 1'b1;
            end else begin
                is_drop = 1'b1;
            end
        end
    end

    // The tracking entry is pushed on the same edge that launches bank_rd_en,
    // so it reaches the tail exactly when the bank data is valid.
    assign trk_in = {is_local, rq_bank};

    glb_shift #(
        .DATA_WIDTH (TRK_W),
        .DEPTH      (TRK_D)
    ) u_trk (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (1'b1),
        .data_in  (trk_in),
        .data_out (trk_tail),
        .stages   (trk_stages)
    );

    assign tail_valid = trk_tail[BSEL_W];
    assign tail_bank  = trk_tail[BSEL_W-1:0];

    always_comb begin
        rd_pending = 1'b0;
        for (int i = 0; i < TRK_D; i++) begin
            rd_pending = rd_pending | trk_stages[i][BSEL_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_rd_en       <= '0;
            bank_rd_addr     <= '0;
            rdrq_packet_esto <= '0;
            rdrq_drop_pulse  <= 1'b0;
            rdrs_packet_wsto <= '0;
            rdrs_collision   <= 1'b0;
        end else begin
            bank_rd_en       <= bank_onehot;
            bank_rd_addr     <= is_local ? rq_byte : '0;
            rdrq_packet_esto <= is_fwd ? rdrq_packet_wsti : '0;
            rdrq_drop_pulse  <= is_drop;

            // Local data has priority; a relayed response arriving in the
            // same cycle is lost and flagged.
            if (tail_valid) begin
                rdrs_packet_wsto.rd_data_valid <= 1'b1;
                rdrs_packet_wsto.rd_data       <= bank_rd_data[tail_bank];
            end else if (rdrs_packet_esti.rd_data_valid) begin
                rdrs_packet_wsto <= rdrs_packet_esti;
            end else begin
                rdrs_packet_wsto <= '0;
            end

            if (tail_valid && rdrs_packet_esti.rd_data_valid) begin
                rdrs_collision <= 1'b1;
            end
        end
    end

endmodule

// File: doc/glb_core_pc_rd_server.md
# glb_core_pc_rd_server

Per-tile responder for the parallel-config read chain. It receives read-request packets travelling west-to-east, decodes the tile field of each address, and then does one of three things:
- serves the request from the tile's local banks with a fixed latency,
- forwards it to the east neighbour,
- drops it when the east link is disconnected.

Read responses travel the chain east-to-west. The block returns them west, merging local responses with responses relayed from further east. It sits between the tile's banks and the PC DMA of whichever tile issued the request.

## Interface
Parameters:
- BANK_RD_LATENCY, 1: cycles from bank_rd_en to valid bank_rd_data (≥1).
- BANKS_PER_TILE, 2: banks per tile; bank select width is BANK_SEL_ADDR_WIDTH = $clog2(BANKS_PER_TILE).

Ports:
- clk  input  1  clock.
- reset  input  1  reset; synchronous, active-high.
- glb_tile_id  input  TILE_SEL_ADDR_WIDTH  this tile's index.
- cfg_tile_connected_east  input  1  1 = east neighbour exists, so forwarding is allowed.
- rdrq_packet_wsti  input  rdrq_packet_t  request from the west (rd_en, rd_addr).
- rdrq_packet_esto  output  rdrq_packet_t  request forwarded east.
- rdrs_packet_esti  input  rdrs_packet_t  response from the east (rd_data_valid, rd_data).
- rdrs_packet_wsto  output  rdrs_packet_t  response toward the west.
- bank_rd_en  output  BANKS_PER_TILE  one-hot bank read strobe.
- bank_rd_addr  output  BANK_ADDR_WIDTH  byte address to the bank.
- bank_rd_data  input  BANKS_PER_TILE×BANK_DATA_WIDTH  bank read data.
- rd_pending  output  1  one or more local reads are in flight.
- rdrs_collision  output  1  sticky error flag, set when a local and a relayed response meet in the same cycle.
- rdrq_drop_pulse  output  1  one-cycle pulse when a request is discarded.

## Operation
Address fields of rd_addr, from MSB to LSB:
- tile = [GLB_ADDR_WIDTH-1 -: TILE_SEL_ADDR_WIDTH]
- bank = next BANK_SEL_ADDR_WIDTH bits
- byte address = low BANK_ADDR_WIDTH bits

bank_rd_addr carries the byte address unmodified. The bank ignores the low 3 bits (8-byte words).

Request path, evaluated each cycle that rdrq_packet_wsti.rd_en = 1:
- tile == glb_tile_id: issue a local read. The next cycle, bank_rd_en[bank] = 1 and bank_rd_addr = byte address. The block pushes {valid, bank} into a tracking shift register.
- tile ≠ glb_tile_id and cfg_tile_connected_east = 1: forward. The next cycle, rdrq_packet_esto = the input packet.
- Otherwise: drop. The next cycle, rdrq_drop_pulse = 1. No bank access and no forwarding occur.
- When rd_en = 0, all request outputs drive 0 the next cycle (rd_addr = '0).

Response path:
- The tracking register is BANK_RD_LATENCY+1 deep. At its tail, valid selects bank_rd_data[bank], which is registered onto rdrs_packet_wsto.
- When no local response is due, rdrs_packet_esti is registered onto rdrs_packet_wsto unchanged.
- If a local response and a relayed response are valid in the same cycle:
  - the local response wins;
  - the relayed response is lost;
  - rdrs_collision sets and stays at 1 until reset.
- When neither response is valid, rdrs_packet_wsto drives rd_data_valid = 0 and rd_data = '0.

rd_pending:
- Equals the OR of all tracking-register valid bits, which is equivalent to a count of outstanding local reads being nonzero.
- Local reads may be issued back-to-back every cycle. There is no backpressure.

## Timing
- Reset: every output and all internal registers go to 0 on the next clk edge while reset = 1. Any in-flight tracking entries are discarded. No response for an aborted read ever appears.
- Request forwarding latency is 1 cycle.
- Local read latency is BANK_RD_LATENCY + 2 cycles from rdrq_packet_wsti.rd_en to rdrs_packet_wsto.rd_data_valid:
  - cycle 0: request on input.
  - cycle 1: bank_rd_en.
  - cycle 1+BANK_RD_LATENCY: data sampled.
  - following edge: data on output.
- Relay latency is 1 cycle from rdrs_packet_esti to rdrs_packet_wsto.
- Round-trip latency for a request served k tiles east: 2k + BANK_RD_LATENCY + 2 cycles. With a single active DMA issuing at most one request per cycle, responses never collide.
- cfg_tile_connected_east is sampled in the same cycle as the request.
- rdrq_drop_pulse and bank_rd_en are each high for exactly one cycle per request.

## Structure
- Add to global_buffer_param: BANK_SEL_ADDR_WIDTH, BANKS_PER_TILE, and BANK_RD_LATENCY defaults.
- rdrq_packet_t and rdrs_packet_t stay in global_buffer_pkg unchanged.
- Sub-module: reuse glb_shift (DATA_WIDTH = 1+BANK_SEL_ADDR_WIDTH, DEPTH = BANK_RD_LATENCY+1, clk_en = 1) for the tracking register.
- All other logic is flat.

## Test plan
- Local read: glb_tile_id = 2, request addr = {tile 2, bank 1, 0x0040}, BANK_RD_LATENCY = 1.
  - Cycle 1: bank_rd_en = 2'b10 and bank_rd_addr = 0x0040.
  - Cycle 3: rdrs rd_data_valid = 1 with bank 1 data (0xDEADBEEF_00000040).
  - rd_pending = 1 during cycles 1–2.
- Forward: request to tile 5 with connected_east = 1 → identical packet on rdrq_packet_esto at cycle 1; no bank_rd_en.
- Drop: request to tile 5 with connected_east = 0 → rdrq_drop_pulse = 1 at cycle 1 only; esto rd_en stays 0.
- Burst: 16 back-to-back local reads with incrementing addresses (+8) → 16 consecutive valid responses, in order, starting at cycle 3; rd_pending falls 1 cycle after the last response is registered.
- Collision: local response due at cycle N and rdrs_packet_esti valid in cycle N-1 → output at N carries local data; rdrs_collision = 1 and stays 1; cleared only by reset.
- Reset mid-read: reset asserted at cycle 2 of a local read → all outputs 0 at cycle 3; no rd_data_valid appears afterwards.
